// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue unit: opcodes, widths,
// FSM state encoding and the packed request format stored in the FIFO.
package alu_pkg;

  localparam int OPND_W = 3;
  localparam int RES_W  = 5;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_REM = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

  // 8-bit FIFO entry laid out as {op, b, a}
  typedef struct packed {
    logic [1:0]        op;
    logic [OPND_W-1:0] b;
    logic [OPND_W-1:0] a;
  } cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Request FIFO for the ALU issue unit: DEPTH entries of {op,b,a}, with an
// occupancy count and empty flag. Push when full and pop when empty are ignored.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  cmd_t                     wdata,
  output cmd_t                     rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: the storage array is deliberately not reset; pointers and count
  // alone decide which entries are valid, so the array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointer wrap is the natural overflow
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_unit.sv
// Issue unit around the external combinational ALU: queues requests, drives
// registered operands, captures result/flags and counts divide-by-zero events.
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int DZ_CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPND_W-1:0]   in_a,
  input  logic [OPND_W-1:0]   in_b,
  input  logic [1:0]          in_op,
  output logic [OPND_W-1:0]   alu_a,
  output logic [OPND_W-1:0]   alu_b,
  output logic [1:0]          alu_s,
  input  logic [RES_W-1:0]    alu_r,
  input  logic                alu_sf,
  input  logic                alu_zf,
  input  logic                alu_dzf,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [RES_W-1:0]    out_r,
  output logic                out_sf,
  output logic                out_zf,
  output logic                out_dzf,
  input  logic                dz_clr,
  output logic [DZ_CNT_W-1:0] dz_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t        state;
  cmd_t          head;
  cmd_t          wdata;
  logic [CW-1:0] count;
  logic          empty;
  logic          push;
  logic          load;
  logic          capture;

  assign wdata    = '{op: in_op, b: in_b, a: in_a};
  assign in_ready = (count < CW'(DEPTH));
  assign push     = in_valid & in_ready;
  assign capture  = (state == EXEC);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    load = 1'b0;
    if (!empty) begin
      if (state == IDLE)                    load = 1'b1;
      else if (state == DONE && out_ready)  load = 1'b1;
    end
  end

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (load),
    .wdata (wdata),
    .rdata (head),
    .count (count),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_s     <= '0;
      out_valid <= 1'b0;
      out_r     <= '0;
      out_sf    <= 1'b0;
      out_zf    <= 1'b0;
      out_dzf   <= 1'b0;
    end else begin
      if (load) begin
        alu_a <= head.a;
        alu_b <= head.b;
        alu_s <= head.op;
      end
      case (state)
        IDLE: if (load) state <= EXEC;
        EXEC: begin
          // one cycle on registered operands lets the ALU settle
          out_r     <= alu_r;
          out_sf    <= alu_sf;
          out_zf    <= alu_zf;
          out_dzf   <= alu_dzf;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= load ? EXEC : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Only genuine remainder-by-zero captures count; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dz_count <= '0;
    end else if (dz_clr) begin
      dz_count <= '0;
    end else if (capture && alu_dzf && alu_s == OP_REM && dz_count != {DZ_CNT_W{1'b1}}) begin
      dz_count <= dz_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Self-checking bench for alu_issue_unit: bench-side ALU model, expected-result
// queue and a saturating divide-by-zero model, driven by scenario tasks.
module tb_alu_issue_unit;
  import alu_pkg::*;

  localparam int DEPTH = 4;
  localparam int DZW   = 2;
  localparam logic [DZW-1:0] DZ_MAX = '1;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [2:0]     in_a;
  logic [2:0]     in_b;
  logic [1:0]     in_op;
  logic [2:0]     alu_a;
  logic [2:0]     alu_b;
  logic [1:0]     alu_s;
  logic [4:0]     alu_r;
  logic           alu_sf;
  logic           alu_zf;
  logic           alu_dzf;
  logic           out_valid;
  logic           out_ready;
  logic [4:0]     out_r;
  logic           out_sf;
  logic           out_zf;
  logic           out_dzf;
  logic           dz_clr;
  logic [DZW-1:0] dz_count;

  typedef struct {
    logic [4:0] r;
    logic       sf;
    logic       zf;
    logic       dzf;
    logic [1:0] op;
  } exp_t;

  exp_t           exp_q[$];
  logic [DZW-1:0] dz_model;
  logic           force_dzf;
  logic [7:0]     alu_m;
  int             n_checks;
  int             n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu_issue_unit #(.DEPTH(DEPTH), .DZ_CNT_W(DZW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_s     (alu_s),
    .alu_r     (alu_r),
    .alu_sf    (alu_sf),
    .alu_zf    (alu_zf),
    .alu_dzf   (alu_dzf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_sf    (out_sf),
    .out_zf    (out_zf),
    .out_dzf   (out_dzf),
    .dz_clr    (dz_clr),
    .dz_count  (dz_count)
  );

  // Behavioural ALU: plain integer arithmetic truncated to 5 bits -> {dzf,zf,sf,r}
  function automatic logic [7:0] alu_fn(input logic [2:0] a, input logic [2:0] b,
                                        input logic [1:0] op);
    int ia, ib, x;
    logic [4:0] r;
    ia = int'(a);
    ib = int'(b);
    case (op)
      OP_ADD:  x = ia + ib;
      OP_SUB:  x = ia - ib;
      OP_MUL:  x = ia * ib;
      default: x = (ib == 0) ? 0 : ia % ib;
    endcase
    r = x[4:0];
    return {(op == OP_REM && ib == 0), (r == 5'd0), r[4], r};
  endfunction

  assign alu_m   = alu_fn(alu_a, alu_b, alu_s);
  assign alu_r   = alu_m[4:0];
  assign alu_sf  = alu_m[5];
  assign alu_zf  = alu_m[6];
  assign alu_dzf = alu_m[7] | force_dzf;

  function automatic exp_t mk_exp(input logic [2:0] a, input logic [2:0] b,
                                  input logic [1:0] op);
    exp_t e;
    logic [7:0] m;
    m     = alu_fn(a, b, op);
    e.r   = m[4:0];
    e.sf  = m[5];
    e.zf  = m[6];
    e.dzf = m[7] | force_dzf;
    e.op  = op;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare the result currently offered against the head of the expected queue
  task automatic consume_result(input string tag);
    exp_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s: unexpected result r=%b with nothing outstanding", tag, out_r);
    end else begin
      e = exp_q.pop_front();
      if (e.dzf && e.op == OP_REM && dz_model != DZ_MAX) dz_model = dz_model + 1'b1;
      if ({out_r, out_sf, out_zf, out_dzf, dz_count} !== {e.r, e.sf, e.zf, e.dzf, dz_model}) begin
        n_errors++;
        $display("FAIL %s: got r=%b sf=%b zf=%b dzf=%b dz=%0d, expected r=%b sf=%b zf=%b dzf=%b dz=%0d",
                 tag, out_r, out_sf, out_zf, out_dzf, dz_count,
                 e.r, e.sf, e.zf, e.dzf, dz_model);
      end
    end
  endtask

  task automatic send(input logic [2:0] a, input logic [2:0] b, input logic [1:0] op,
                      input string tag);
    int w;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    w = 0;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: in_ready stuck low, got %b expected 1", tag, in_ready);
    end else begin
      exp_q.push_back(mk_exp(a, b, op));
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n, input bit chk_gap, input string tag);
    int got, last, cyc;
    got  = 0;
    last = -1;
    cyc  = 0;
    out_ready = 1'b1;
    while (got < n && cyc < 200) begin
      if (out_valid) begin
        consume_result(tag);
        if (chk_gap && last >= 0) begin
          n_checks++;
          if (cyc - last != 2) begin
            n_errors++;
            $display("FAIL %s_gap: got spacing %0d expected 2", tag, cyc - last);
          end
        end
        last = cyc;
        got++;
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    if (got != n) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: got %0d results expected %0d", tag, got, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({in_ready, out_valid, alu_a, alu_b, alu_s, out_r, out_sf, out_zf, out_dzf, dz_count}
        !== {1'b1, 1'b0, 3'd0, 3'd0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0, {DZW{1'b0}}}) begin
      n_errors++;
      $display("FAIL reset_state: got rdy=%b ov=%b a=%b b=%b s=%b r=%b dz=%0d expected rdy=1 rest 0",
               in_ready, out_valid, alu_a, alu_b, alu_s, out_r, dz_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_op();
    send(3'b011, 3'b010, OP_ADD, "single_push");
    tick();
    n_checks++;
    if ({alu_a, alu_b, alu_s, out_valid} !== {3'b011, 3'b010, 2'b00, 1'b0}) begin
      n_errors++;
      $display("FAIL single_load: got a=%b b=%b s=%b ov=%b expected a=011 b=010 s=00 ov=0",
               alu_a, alu_b, alu_s, out_valid);
    end
    tick();
    n_checks++;
    if ({out_valid, out_r, out_sf, out_zf, out_dzf} !== {1'b1, 5'b00101, 1'b0, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL single_capture: got ov=%b r=%b sf=%b zf=%b dzf=%b expected ov=1 r=00101 flags 0",
               out_valid, out_r, out_sf, out_zf, out_dzf);
    end
    drain(1, 1'b0, "single_out");
  endtask

  task automatic test_divide_by_zero();
    dz_clr = 1'b1;
    tick();
    dz_clr   = 1'b0;
    dz_model = '0;
    n_checks++;
    if (dz_count !== '0) begin
      n_errors++;
      $display("FAIL dz_clear: got %0d expected 0", dz_count);
    end
    send(3'($urandom), 3'b000, OP_REM, "dz_rem_push");
    drain(1, 1'b0, "dz_rem");
    force_dzf = 1'b1;
    send(3'($urandom), 3'($urandom), OP_SUB, "dz_sub_push");
    drain(1, 1'b0, "dz_sub");
    force_dzf = 1'b0;
    send(3'b101, 3'b011, OP_REM, "rem_ok_push");
    drain(1, 1'b0, "rem_ok");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 4; i++) send(3'($urandom), 3'b000, OP_REM, "sat_push");
    drain(4, 1'b0, "sat");
    n_checks++;
    if (dz_count !== DZ_MAX) begin
      n_errors++;
      $display("FAIL sat_hold: got %0d expected %0d", dz_count, DZ_MAX);
    end
    // clear lands on the same edge as a DZ capture
    send(3'b110, 3'b000, OP_REM, "clr_push");
    tick();
    dz_clr = 1'b1;
    tick();
    dz_clr = 1'b0;
    dz_model = '0;
    n_checks++;
    if ({out_valid, out_dzf, dz_count} !== {1'b1, 1'b1, {DZW{1'b0}}}) begin
      n_errors++;
      $display("FAIL clr_priority: got ov=%b dzf=%b dz=%0d expected ov=1 dzf=1 dz=0",
               out_valid, out_dzf, dz_count);
    end
    void'(exp_q.pop_front());
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(3'($urandom), 3'($urandom), 2'($urandom), "bp_push");
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_full: in_ready got %b expected 0", in_ready);
    end
    in_valid = 1'b1;
    in_a     = 3'($urandom);
    in_b     = 3'($urandom);
    in_op    = 2'($urandom);
    tick();
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({in_ready, out_valid, out_r} !== {1'b0, 1'b1, exp_q[0].r}) begin
      n_errors++;
      $display("FAIL bp_hold: got rdy=%b ov=%b r=%b expected rdy=0 ov=1 r=%b",
               in_ready, out_valid, out_r, exp_q[0].r);
    end
    drain(5, 1'b1, "bp_out");
    repeat (4) tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_sixth: out_valid got %b expected 0 (sixth push must be dropped)", out_valid);
    end
  endtask

  task automatic test_simultaneous();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(3'($urandom), 3'($urandom), 2'($urandom), "sim_push");
    n_checks++;
    if ({out_valid, in_ready} !== 2'b11) begin
      n_errors++;
      $display("FAIL sim_setup: got ov=%b rdy=%b expected ov=1 rdy=1", out_valid, in_ready);
    end
    in_valid  = 1'b1;
    in_a      = 3'($urandom);
    in_b      = 3'($urandom);
    in_op     = 2'($urandom);
    out_ready = 1'b1;
    consume_result("sim_first");
    exp_q.push_back(mk_exp(in_a, in_b, in_op));
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    send(3'($urandom), 3'($urandom), 2'($urandom), "sim_fill3");
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL sim_count3: in_ready got %b expected 1", in_ready);
    end
    send(3'($urandom), 3'($urandom), 2'($urandom), "sim_fill4");
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL sim_count4: in_ready got %b expected 0", in_ready);
    end
    drain(5, 1'b1, "sim_out");
  endtask

  task automatic test_random_stream();
    for (int c = 0; c < 300; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_a      = 3'($urandom);
      in_b      = 3'($urandom);
      in_op     = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if (out_valid && out_ready) consume_result("rand");
      if (in_valid && in_ready) exp_q.push_back(mk_exp(in_a, in_b, in_op));
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drain(exp_q.size(), 1'b0, "rand_tail");
  endtask

  task automatic test_reset_mid_op();
    out_ready = 1'b0;
    send(3'b011, 3'b001, OP_ADD, "rst_push1");
    send(3'b101, 3'b010, OP_SUB, "rst_push2");
    send(3'($urandom), 3'($urandom), 2'($urandom), "rst_push3");
    send(3'($urandom), 3'($urandom), 2'($urandom), "rst_push4");
    in_valid  = 1'b1;
    in_a      = 3'($urandom);
    in_b      = 3'($urandom);
    in_op     = 2'($urandom);
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, out_valid, alu_a, alu_b, alu_s, out_r, out_sf, out_zf, out_dzf, dz_count}
        !== {1'b1, 1'b0, 3'd0, 3'd0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0, {DZW{1'b0}}}) begin
      n_errors++;
      $display("FAIL rst_async: got rdy=%b ov=%b a=%b b=%b s=%b r=%b dz=%0d expected rdy=1 rest 0",
               in_ready, out_valid, alu_a, alu_b, alu_s, out_r, dz_count);
    end
    exp_q.delete();
    dz_model = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
        n_errors++;
        $display("FAIL rst_quiet: got rdy=%b ov=%b expected rdy=1 ov=0", in_ready, out_valid);
      end
    end
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    dz_model  = '0;
    force_dzf = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = '0;
    out_ready = 1'b0;
    dz_clr    = 1'b0;
    rst_n     = 1'b1;
    #1;
    test_reset();
    test_single_op();
    test_divide_by_zero();
    test_saturation();
    test_backpressure();
    test_simultaneous();
    test_random_stream();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
